// File: rtl/mem_slave_pipe.sv
// Parameterised single-port memory slave: byte-strobed writes, RD_LAT-stage read pipe, range error.
// Optional power-up clear sweep enabled by defining MEM_CLEAR_EN.
module mem_slave_pipe #(
    parameter int DW     = 16,
    parameter int AW     = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            write,
    input  logic [AW-1:0]   address,
    input  logic [DW-1:0]   data_in,
    input  logic [DW/8-1:0] be,
    output logic            ready,
    output logic            rvalid,
    output logic [DW-1:0]   data_out,
    output logic            err
);

    localparam int NB = DW / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic              ready_q;
    logic              ready_d;
    logic              clr_we;
    logic [IW-1:0]     clr_idx;

    logic              acc;
    logic              rd_acc;
    logic              wr_acc;
    logic              in_rng;
    logic [IW-1:0]     idx;

    logic [DW-1:0]     mem_q [DEPTH];

    logic [RD_LAT-1:0] v_q;
    logic [RD_LAT-1:0] e_q;
    logic [DW-1:0]     d_q [RD_LAT];
    logic              werr_q;

`ifdef MEM_CLEAR_EN
    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_e;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e        state_q;
    state_e        state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Sweep writes one word per cycle; ready rises with the last clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        clr_we  = 1'b0;
        clr_idx = cnt_q[IW-1:0];
        unique case (state_q)
            S_INIT: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end
            end
            S_IDLE: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end
`else
    assign ready_d = 1'b1;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end
`endif

    assign acc    = req & ready_q;
    assign rd_acc = acc & ~write;
    assign wr_acc = acc & write;
    assign in_rng = {1'b0, address} < DEPTH_W;
    assign idx    = address[IW-1:0];

    // Storage is deliberately not reset; only the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_idx] <= '0;
        end else if (wr_acc && in_rng) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= data_in[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            e_q    <= '0;
            werr_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q[0] <= rd_acc;
            e_q[0] <= rd_acc & ~in_rng;
            if (rd_acc) begin
                d_q[0] <= in_rng ? mem_q[idx] : '1;
            end
            // Data only advances with a valid so data_out holds between responses.
            for (int i = 1; i < RD_LAT; i++) begin
                v_q[i] <= v_q[i-1];
                e_q[i] <= e_q[i-1];
                if (v_q[i-1]) begin
                    d_q[i] <= d_q[i-1];
                end
            end
            werr_q <= wr_acc & ~in_rng;
        end
    end

    assign ready    = ready_q;
    assign rvalid   = v_q[RD_LAT-1];
    assign data_out = d_q[RD_LAT-1];
    assign err      = (v_q[RD_LAT-1] & e_q[RD_LAT-1]) | werr_q;

endmodule
